// File: rtl/sub64_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sub64_pipe
//  Purpose  : Four-stage pipelined 64-bit subtractor, diff = a - b - bin, with
//             borrow-out. Each stage resolves one 16-bit carry-select slice.
//             The pipeline uses valid/ready handshakes on both sides and a
//             single global advance, so it stalls cleanly under backpressure.
//  Options  : SUB64_OVF_EN - adds the registered signed-overflow output ovf_o.
//  Revision : 1.0 - initial release
// ============================================================================
module sub64_pipe #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SUB64_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  // Widths of the operand bits still to be consumed after each stage.
  localparam int REM1 = WIDTH - SLICE;
  localparam int REM2 = WIDTH - 2 * SLICE;
  localparam int REM3 = WIDTH - 3 * SLICE;

  // One slice subtraction; bit SLICE of the result is the borrow-out, which
  // is set exactly when x < y + bi.
  function automatic logic [SLICE:0] slice_sub(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             bi);
    slice_sub = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bi};
  endfunction

  // Pipeline state: valid bit, completed low diff bits, borrow into the
  // next slice, and the not-yet-consumed upper operand bits.
  logic                   v1_q, v2_q, v3_q, v4_q;
  logic [SLICE-1:0]       s1_diff_q, s1_diff_d;
  logic                   s1_br_q, s1_br_d;
  logic [REM1-1:0]        s1_a_q, s1_b_q;
  logic [2*SLICE-1:0]     s2_diff_q, s2_diff_d;
  logic                   s2_br_q, s2_br_d;
  logic [REM2-1:0]        s2_a_q, s2_b_q;
  logic [3*SLICE-1:0]     s3_diff_q, s3_diff_d;
  logic                   s3_br_q, s3_br_d;
  logic [REM3-1:0]        s3_a_q, s3_b_q;
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic                   bout_q, bout_d;
`ifdef SUB64_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  // Both borrow-in variants of every slice are formed up front; the registered
  // borrow from the previous stage only drives the final select.
  logic [SLICE:0] st1_r0, st1_r1, st1_sel;
  logic [SLICE:0] st2_r0, st2_r1, st2_sel;
  logic [SLICE:0] st3_r0, st3_r1, st3_sel;
  logic [SLICE:0] st4_r0, st4_r1, st4_sel;
  logic           adv;

  // Whole pipeline moves together unless the output is held by backpressure.
  assign adv        = !v4_q || out_ready_i;
  assign in_ready_o = adv;

  // Carry-select slice arithmetic and next-state formation for every stage.
  always_comb begin
    st1_r0    = slice_sub(a_i[SLICE-1:0], b_i[SLICE-1:0], 1'b0);
    st1_r1    = slice_sub(a_i[SLICE-1:0], b_i[SLICE-1:0], 1'b1);
    st1_sel   = bin_i ? st1_r1 : st1_r0;
    s1_diff_d = st1_sel[SLICE-1:0];
    s1_br_d   = st1_sel[SLICE];

    st2_r0    = slice_sub(s1_a_q[SLICE-1:0], s1_b_q[SLICE-1:0], 1'b0);
    st2_r1    = slice_sub(s1_a_q[SLICE-1:0], s1_b_q[SLICE-1:0], 1'b1);
    st2_sel   = s1_br_q ? st2_r1 : st2_r0;
    s2_diff_d = {st2_sel[SLICE-1:0], s1_diff_q};
    s2_br_d   = st2_sel[SLICE];

    st3_r0    = slice_sub(s2_a_q[SLICE-1:0], s2_b_q[SLICE-1:0], 1'b0);
    st3_r1    = slice_sub(s2_a_q[SLICE-1:0], s2_b_q[SLICE-1:0], 1'b1);
    st3_sel   = s2_br_q ? st3_r1 : st3_r0;
    s3_diff_d = {st3_sel[SLICE-1:0], s2_diff_q};
    s3_br_d   = st3_sel[SLICE];

    st4_r0    = slice_sub(s3_a_q, s3_b_q, 1'b0);
    st4_r1    = slice_sub(s3_a_q, s3_b_q, 1'b1);
    st4_sel   = s3_br_q ? st4_r1 : st4_r0;
    diff_d    = {st4_sel[SLICE-1:0], s3_diff_q};
    bout_d    = st4_sel[SLICE];
`ifdef SUB64_OVF_EN
    // Sign bits of a and b are still in the stage-3 skew registers here.
    ovf_d     = (s3_a_q[SLICE-1] != s3_b_q[SLICE-1]) &&
                (st4_sel[SLICE-1] != s3_a_q[SLICE-1]);
`endif
  end

  // Pipeline registers: clear on reset, shift on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      v4_q      <= 1'b0;
      s1_diff_q <= '0;
      s1_br_q   <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_diff_q <= '0;
      s2_br_q   <= 1'b0;
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      s3_diff_q <= '0;
      s3_br_q   <= 1'b0;
      s3_a_q    <= '0;
      s3_b_q    <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
`ifdef SUB64_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else if (adv) begin
      // A missing input simply becomes a bubble in stage 1.
      v1_q      <= in_valid_i;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      v4_q      <= v3_q;
      s1_diff_q <= s1_diff_d;
      s1_br_q   <= s1_br_d;
      s1_a_q    <= a_i[WIDTH-1:SLICE];
      s1_b_q    <= b_i[WIDTH-1:SLICE];
      s2_diff_q <= s2_diff_d;
      s2_br_q   <= s2_br_d;
      s2_a_q    <= s1_a_q[REM1-1:SLICE];
      s2_b_q    <= s1_b_q[REM1-1:SLICE];
      s3_diff_q <= s3_diff_d;
      s3_br_q   <= s3_br_d;
      s3_a_q    <= s2_a_q[REM2-1:SLICE];
      s3_b_q    <= s2_b_q[REM2-1:SLICE];
      diff_q    <= diff_d;
      bout_q    <= bout_d;
`ifdef SUB64_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign out_valid_o = v4_q;
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;
`ifdef SUB64_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub64_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub64_pipe
//  Purpose  : Scoreboard bench for sub64_pipe. The driver pushes hand-computed
//             expectations when an operand is accepted; an independent monitor
//             pops and compares whenever a result is transferred out.
//  Options  : SUB64_OVF_EN - also connects and checks ovf_o.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sub64_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        bin_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] diff_o;
  logic        bout_o;
`ifdef SUB64_OVF_EN
  logic        ovf_o;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sub64_pipe #(.WIDTH(64), .SLICE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .bin_i       (bin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .diff_o      (diff_o),
    .bout_o      (bout_o)
`ifdef SUB64_OVF_EN
    ,
    .ovf_o       (ovf_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every output transfer is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {63'd0, out_valid_o}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", diff_o, e.d);
        check("bout", {63'd0, bout_o}, {63'd0, e.bo});
`ifdef SUB64_OVF_EN
        check("ovf", {63'd0, ovf_o}, {63'd0, e.ov});
`endif
      end
    end
  end

  // Offer one operand (called at posedge+1), wait for acceptance, push the
  // expectation, and return at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bi,
                      input logic [63:0] d, input logic bo, input logic ov,
                      output int waits);
    exp_t e;
    waits      = 0;
    in_valid_i = 1'b1;
    a_i        = a;
    b_i        = b;
    bin_i      = bi;
    @(negedge clk);
    while (!in_ready_o && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready_o) begin
      e.d = d; e.bo = bo; e.ov = ov;
      sb.push_back(e);
    end else begin
      check("accept_timeout", {63'd0, in_ready_o}, 64'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int w;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_diff", diff_o, 64'd0);
    check("rst_bout", {63'd0, bout_o}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
`ifdef SUB64_OVF_EN
    check("rst_ovf", {63'd0, ovf_o}, 64'd0);
`endif
    @(posedge clk); #1;

    // Basic operation and latency: valid appears on the 4th cycle after accept
    send(64'd5, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, w);
    in_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("latency_valid", {63'd0, out_valid_o}, (k == 4) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
    drain();

    // Wrap and cross-slice borrow
    send(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, w);
    send(64'd12, 64'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, w);
    send(64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, w);
    in_valid_i = 1'b0;
    drain();

    // Throughput: ten back-to-back operands, never waiting on in_ready
    send(64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, w);
    check("tput_wait0", 64'(w), 64'd0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, w);
    check("tput_wait1", 64'(w), 64'd0);
    send(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, w);
    check("tput_wait2", 64'(w), 64'd0);
    send(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, w);
    check("tput_wait3", 64'(w), 64'd0);
    send(64'h0001_0000_0000_0000, 64'd1, 1'b1, 64'h0000_FFFF_FFFF_FFFE, 1'b0, 1'b0, w);
    check("tput_wait4", 64'(w), 64'd0);
    send(64'h1234, 64'h1235, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, w);
    check("tput_wait5", 64'(w), 64'd0);
    // 99812398123 - 9213123 = 99803185000
    send(64'd99812398123, 64'd9213123, 1'b0, 64'd99803185000, 1'b0, 1'b0, w);
    check("tput_wait6", 64'(w), 64'd0);
    send(64'd1000, 64'd2000, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 1'b1, 1'b0, w);
    check("tput_wait7", 64'(w), 64'd0);
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
         64'h5555_5555_5555_5555, 1'b0, 1'b1, w);
    check("tput_wait8", 64'(w), 64'd0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b0, 1'b0, w);
    check("tput_wait9", 64'(w), 64'd0);
    in_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("tput_all_out", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Backpressure: fill all four stages with the output blocked
    out_ready_i = 1'b0;
    send(64'd50, 64'd8, 1'b0, 64'd42, 1'b0, 1'b0, w);
    send(64'd7, 64'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, w);
    send(64'h2_0000, 64'h1_0001, 1'b0, 64'hFFFF, 1'b0, 1'b0, w);
    send(64'd3, 64'd1, 1'b1, 64'd1, 1'b0, 1'b0, w);
    in_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
      check("stall_valid", {63'd0, out_valid_o}, 64'd1);
      check("stall_diff", diff_o, 64'd42);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("stall_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Reset with three tokens in flight; the transfer offered during reset is dropped
    send(64'd10, 64'd1, 1'b0, 64'd9, 1'b0, 1'b0, w);
    send(64'd20, 64'd2, 1'b0, 64'd18, 1'b0, 1'b0, w);
    send(64'd30, 64'd3, 1'b0, 64'd27, 1'b0, 1'b0, w);
    rst = 1'b1;
    sb.delete();
    in_valid_i = 1'b1; a_i = 64'd777; b_i = 64'd1; bin_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_valid", {63'd0, out_valid_o}, 64'd0);
    end
    @(posedge clk); #1;
    send(64'd2048, 64'd1024, 1'b0, 64'd1024, 1'b0, 1'b0, w);
    in_valid_i = 1'b0;
    drain();

    // Signed overflow cases
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, w);
    send(64'd1, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, w);
    in_valid_i = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    checks++;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
